// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST session controller.
package bist_pkg;

  localparam int DEFAULT_SIG_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    FLUSH,
    COMPARE,
    DONE
  } bist_state_t;

  // Wide enough for the pattern count plus the deepest CUT latency.
  function automatic int cntWidth(input int patternCount);
    return $clog2(patternCount + 8);
  endfunction

endpackage

// File: rtl/bist_cycle_counter.sv
// Loadable down-counter; holds at zero so the terminal count stays asserted.
module bist_cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] loadValue,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] countReg;

  always_ff @(posedge clock) begin
    if (reset) begin
      countReg <= '0;
    end else if (load) begin
      countReg <= loadValue;
    end else if (en && !terminal) begin
      countReg <= countReg - 1'b1;
    end
  end

  assign count    = countReg;
  assign terminal = (countReg == '0);

endmodule

// File: rtl/bist_sequencer.sv
// Session controller for TPG -> CUT -> MISR self-test: clear, run patterns,
// flush CUT latency, compare the MISR signature against the golden value.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int                   PATTERN_COUNT = 15,
  parameter int                   CUT_LATENCY   = 0,
  parameter int                   SIG_WIDTH     = DEFAULT_SIG_WIDTH,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG    = SIG_WIDTH'(4'hA)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SIG_WIDTH-1:0] misr_sig,
  output logic                 test_mode,
  output logic                 tpg_clear,
  output logic                 tpg_en,
  output logic                 misr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int CW = cntWidth(PATTERN_COUNT);
  localparam logic [CW-1:0] RUN_LOAD   = CW'(PATTERN_COUNT - 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'((CUT_LATENCY > 0) ? CUT_LATENCY - 1 : 0);

  bist_state_t stateReg, stateNext;

  logic          cntLoad;
  logic          cntEn;
  logic [CW-1:0] cntLoadValue;
  logic [CW-1:0] cntValue;
  logic          cntTerminal;
  logic          sessionActive;

  logic                 passReg, failReg;
  logic [SIG_WIDTH-1:0] sigReg;

  bist_cycle_counter #(
    .WIDTH(CW)
  ) cycleCounter (
    .clock    (clock),
    .reset    (reset),
    .load     (cntLoad),
    .en       (cntEn),
    .loadValue(cntLoadValue),
    .count    (cntValue),
    .terminal (cntTerminal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  assign sessionActive = (stateReg == INIT) || (stateReg == RUN) ||
                         (stateReg == FLUSH) || (stateReg == COMPARE);

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (start) stateNext = INIT;
      INIT:    stateNext = abort ? IDLE : RUN;
      RUN: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (cntTerminal) begin
          stateNext = (CUT_LATENCY > 0) ? FLUSH : COMPARE;
        end
      end
      FLUSH: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (cntTerminal) begin
          stateNext = COMPARE;
        end
      end
      COMPARE: stateNext = abort ? IDLE : DONE;
      DONE:    if (start) stateNext = INIT;
      default: stateNext = IDLE;
    endcase
  end

  // The counter is reloaded on every state entry; only RUN and FLUSH use it.
  always_comb begin
    cntLoad      = (stateNext != stateReg);
    cntEn        = (stateReg == RUN) || (stateReg == FLUSH);
    cntLoadValue = '0;
    if (stateNext == RUN) begin
      cntLoadValue = RUN_LOAD;
    end else if (stateNext == FLUSH) begin
      cntLoadValue = FLUSH_LOAD;
    end
  end

  always_comb begin
    test_mode = 1'b0;
    tpg_clear = 1'b0;
    tpg_en    = 1'b0;
    misr_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (stateReg)
      INIT: begin
        test_mode = 1'b1;
        tpg_clear = 1'b1;
        busy      = 1'b1;
      end
      RUN: begin
        test_mode = 1'b1;
        tpg_en    = 1'b1;
        busy      = 1'b1;
        // RUN index = PATTERN_COUNT-1-count; capture starts once the CUT pipe is full.
        misr_en   = (int'(cntValue) + CUT_LATENCY) <= (PATTERN_COUNT - 1);
      end
      FLUSH: begin
        test_mode = 1'b1;
        misr_en   = 1'b1;
        busy      = 1'b1;
      end
      COMPARE: begin
        test_mode = 1'b1;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      passReg <= 1'b0;
      failReg <= 1'b0;
      sigReg  <= '0;
    end else if (abort && sessionActive) begin
      passReg <= 1'b0;
      failReg <= 1'b0;
      sigReg  <= '0;
    end else if (stateReg == COMPARE) begin
      sigReg  <= misr_sig;
      passReg <= (misr_sig == GOLDEN_SIG);
      failReg <= (misr_sig != GOLDEN_SIG);
    end else if ((stateNext == INIT) && (stateReg != INIT)) begin
      passReg <= 1'b0;
      failReg <= 1'b0;
    end
  end

  assign pass      = passReg;
  assign fail      = failReg;
  assign signature = sigReg;

endmodule

// File: tb/tb_bist_sequencer.sv
// Scoreboard bench for bist_sequencer: default instance plus a CUT_LATENCY=2 instance.
module tb_bist_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] misr;
  logic       sel;

  logic       start0, abort0, startL, abortL;
  logic       tm0, clr0, te0, me0, busy0, done0, pass0, fail0;
  logic       tmL, clrL, teL, meL, busyL, doneL, passL, failL;
  logic [3:0] sig0, sigL;

  logic [11:0] allOut0, allOutL, allOut;
  logic        oTpgClear, oTpgEn, oMisrEn, oBusy, oDone, oPass, oFail;
  logic [3:0]  oSig;

  int assertCount = 0;
  int failCount   = 0;
  logic [5:0] expQ[$];

  assign start0 = start && !sel;
  assign abort0 = abort && !sel;
  assign startL = start && sel;
  assign abortL = abort && sel;

  bist_sequencer dut0 (
    .clock(clk), .reset(reset), .start(start0), .abort(abort0), .misr_sig(misr),
    .test_mode(tm0), .tpg_clear(clr0), .tpg_en(te0), .misr_en(me0), .busy(busy0),
    .done(done0), .pass(pass0), .fail(fail0), .signature(sig0)
  );

  bist_sequencer #(.CUT_LATENCY(2)) dutLat (
    .clock(clk), .reset(reset), .start(startL), .abort(abortL), .misr_sig(misr),
    .test_mode(tmL), .tpg_clear(clrL), .tpg_en(teL), .misr_en(meL), .busy(busyL),
    .done(doneL), .pass(passL), .fail(failL), .signature(sigL)
  );

  assign allOut0 = {tm0, clr0, te0, me0, busy0, done0, pass0, fail0, sig0};
  assign allOutL = {tmL, clrL, teL, meL, busyL, doneL, passL, failL, sigL};
  assign allOut  = sel ? allOutL : allOut0;
  assign oTpgClear = allOut[10];
  assign oTpgEn    = allOut[9];
  assign oMisrEn   = allOut[8];
  assign oBusy     = allOut[7];
  assign oDone     = allOut[6];
  assign oPass     = allOut[5];
  assign oFail     = allOut[4];
  assign oSig      = allOut[3:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Edge 1 is the edge that samples start; abortAt/restartAt are RUN cycle indices (-1 = none).
  task automatic runSession(input logic [3:0] sig, input int lat, input int abortAt,
                            input int restartAt);
    int e = 0, clrCnt = 0, tpgCnt = 0, misrCnt = 0, bad = 0;
    int tpgFirst = -1, tpgLast = -1, misrFirst = -1, misrLast = -1;
    bit finished = 1'b0;
    logic [5:0] exp;
    misr = sig;
    if (abortAt < 0) expQ.push_back({sig == 4'hA, sig != 4'hA, sig});
    start = 1'b1;
    while (!finished && e < 80) begin
      @(posedge clk);
      e++;
      #1;
      start = (restartAt >= 0) && (e == restartAt + 2);
      if (e == 1) check("initClear", {oDone, oPass, oFail, oTpgClear, oBusy}, 5'b00011);
      if (oTpgClear) clrCnt++;
      if (oTpgEn) begin
        if (tpgFirst < 0) tpgFirst = e;
        tpgLast = e;
        tpgCnt++;
      end
      if (oMisrEn) begin
        if (misrFirst < 0) misrFirst = e;
        misrLast = e;
        misrCnt++;
      end
      if ((oPass || oFail) && !oDone) bad++;
      if (oPass && oFail) bad++;
      if (abortAt >= 0 && e == abortAt + 3) begin
        check("abortOut", allOut, 0);
        abort = 1'b0;
        finished = 1'b1;
      end else if (abortAt >= 0 && e == abortAt + 2) begin
        abort = 1'b1;
      end else if (oDone) begin
        finished = 1'b1;
        check("doneEdge", e, 18 + lat);
        check("clrCnt", clrCnt, 1);
        check("tpgCnt", tpgCnt, 15);
        check("tpgContig", tpgLast - tpgFirst + 1, tpgCnt);
        check("misrCnt", misrCnt, 15);
        check("misrContig", misrLast - misrFirst + 1, misrCnt);
        check("misrDelay", misrFirst - tpgFirst, lat);
        if (expQ.size() == 0) begin
          check("sbEmpty", 1, 0);
        end else begin
          exp = expQ.pop_front();
          check("pass", oPass, exp[5]);
          check("fail", oFail, exp[4]);
          check("signature", oSig, exp[3:0]);
        end
        $display("session sig=%h lat=%0d done@%0d pass=%b fail=%b signature=%h",
                 sig, lat, e, oPass, oFail, oSig);
      end
    end
    start = 1'b0;
    if (!finished) check("timeout", 0, 1);
    check("passFailExcl", bad, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    misr  = 4'h0;
    sel   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("resetOut0", allOut0, 0);
    check("resetOutL", allOutL, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idleOut", allOut0, 0);

    runSession(4'hA, 0, -1, -1);
    runSession(4'h5, 0, -1, -1);
    repeat (20) @(posedge clk);
    #1;
    check("doneHold", {oDone, oPass, oFail, oSig}, {3'b101, 4'h5});
    $display("hold 20 cycles done=%b fail=%b signature=%h", oDone, oFail, oSig);

    runSession(4'hA, 0, -1, 3);
    runSession(4'hA, 0, 7, -1);
    $display("abort at RUN cycle 7 outputs=%h", allOut);
    runSession(4'hA, 0, -1, -1);

    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("startBeatsAbort", {oBusy, oTpgClear, oDone}, 3'b110);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abortInInit", allOut, 0);
    $display("start+abort in DONE busy->INIT, then abort outputs=%h", allOut);

    misr  = 4'hA;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midRunBusy", oBusy, 1);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("resetMidRun", allOut, 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("noLaunch", allOut, 0);
    $display("reset mid-RUN outputs=%h", allOut);
    runSession(4'hA, 0, -1, -1);

    sel = 1'b1;
    runSession(4'hA, 2, -1, -1);

    check("sbDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
- Controller for the BIST datapath: LFSR test-pattern generator (TPG) -> circuit under test (CUT) -> 4-bit MISR.
- Sequences one self-test session: synchronous clear of TPG/MISR, a fixed number of pattern cycles, and a flush for CUT pipeline latency.
- Compares the final MISR signature against a golden value and reports pass/fail.
- Sits above the TPG/MISR instances; drives their enables and clears; drives the functional/test input mux select.

Parameters:
- PATTERN_COUNT, 15, number of TPG patterns applied per session (>=1).
- CUT_LATENCY, 0, CUT pipeline depth in cycles between TPG output and MISR input (0..7).
- SIG_WIDTH, 4, MISR signature width.
- GOLDEN_SIG, 4'hA, expected fault-free signature.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- start  in  1  begin a session; sampled in IDLE or DONE only.
- abort  in  1  terminate the session; returns to IDLE.
- misr_sig  in  SIG_WIDTH  current MISR dataOut.
- test_mode  out  1  selects TPG patterns into the CUT.
- tpg_clear  out  1  synchronous clear to TPG and MISR (seed load).
- tpg_en  out  1  TPG advance enable.
- misr_en  out  1  MISR capture enable.
- busy  out  1  session in progress (INIT through COMPARE).
- done  out  1  session finished; result valid.
- pass  out  1  signature matched GOLDEN_SIG.
- fail  out  1  signature mismatched.
- signature  out  SIG_WIDTH  latched final signature.

Behaviour:
- Reset: state=IDLE; all outputs 0, including signature=0. Reset wins over start and abort.
- States: IDLE, INIT, RUN, FLUSH, COMPARE, DONE.
- IDLE: all outputs 0. start=1 -> INIT.
- INIT: one cycle. tpg_clear=1, test_mode=1, busy=1. On entry, done/pass/fail are cleared. -> RUN.
- RUN: exactly PATTERN_COUNT cycles. tpg_en=1, test_mode=1, busy=1.
  - misr_en=1 only from RUN cycle index CUT_LATENCY onward (index counted from 0).
  - Last RUN cycle -> FLUSH if CUT_LATENCY>0, else -> COMPARE.
- FLUSH: exactly CUT_LATENCY cycles. tpg_en=0, misr_en=1, test_mode=1, busy=1. -> COMPARE.
- misr_en count: always exactly PATTERN_COUNT cycles per session.
- COMPARE: one cycle. test_mode=1, busy=1, all enables 0.
  - Registers signature<=misr_sig; pass<=(misr_sig==GOLDEN_SIG); fail<=~pass. -> DONE.
- DONE: done=1; pass/fail/signature held; test_mode=0, busy=0.
  - start=1 -> INIT (new session).
  - Otherwise stay in DONE indefinitely.
- Latency: done rises PATTERN_COUNT+CUT_LATENCY+3 edges after the edge that samples start (18 for the defaults).
- start while busy: ignored.
- abort: in INIT/RUN/FLUSH/COMPARE -> IDLE next edge; all outputs 0, pass=fail=0. Ignored in IDLE/DONE.
  - abort and start in the same cycle while in DONE: start wins.
- pass and fail are never both 1. Both are 0 whenever done=0.
- Counter: one shared cycle counter, width $clog2(PATTERN_COUNT+8). Loaded at each state entry. No wrap: the terminal count causes the state exit.

Decomposition:
- Package bist_pkg:
  - state enum bist_state_t (IDLE, INIT, RUN, FLUSH, COMPARE, DONE).
  - SIG_WIDTH default constant.
  - Function computing counter width.
- Sub-module: bist_cycle_counter.
  - Loadable down-counter with load, en, and terminal-count flag.
  - Instantiated once.
- FSM and compare logic live in bist_sequencer.

Test Plan:
1. Defaults, start pulse 1 cycle, misr_sig=4'hA at COMPARE -> tpg_clear high 1 cycle; tpg_en and misr_en each high 15 consecutive cycles; done=1 at edge 18; pass=1, fail=0, signature=4'hA.
2. Defaults, misr_sig=4'h5 at COMPARE -> done=1, pass=0, fail=1, signature=4'h5; state held in DONE for 20 idle cycles.
3. CUT_LATENCY=2 -> tpg_en high 15 cycles; misr_en rises 2 cycles after tpg_en and stays high 15 cycles; done at edge 20.
4. abort at RUN cycle 7 -> next edge: busy=0, test_mode=0, all enables 0, done=pass=fail=0. A fresh start then completes normally with pass=1.
5. start re-pulsed at RUN cycle 3 -> ignored; done timing unchanged (edge 18). start in DONE -> INIT clears done/pass/fail and a second session runs.
6. reset asserted mid-RUN together with start -> all outputs 0 next edge, state IDLE; no session launches until start is reasserted after reset deasserts.
